// File: rtl/layer1_pool_window_buffer_pkg.sv
// rtl/layer1_pool_window_buffer_pkg.sv - shared layer-1 pool window constants
package layer1_pool_window_buffer_pkg;

   // Quantisation of one value and its log2, used for shift-based indexing
   localparam int pool_bits        = 16;
   localparam int pool_bits_shift  = 4;

   // One pool unit per channel
   localparam int pool_channel_num = 16;

   // Layer-1 convolution output frame geometry
   localparam int pool_img_width   = 24;
   localparam int pool_img_height  = 24;
   localparam int pool_cnt_bits    = 5;

   // Bit offsets of the four window positions inside one channel's 64-bit slot
   localparam int win_off_tl = 0;
   localparam int win_off_tr = 16;
   localparam int win_off_bl = 32;
   localparam int win_off_br = 48;

endpackage

// File: rtl/layer1_pool_window_buffer_pool_line_buffer.sv
// rtl/layer1_pool_window_buffer_pool_line_buffer.sv - one-row pixel store, 1 write / 2 async reads
module layer1_pool_window_buffer_pool_line_buffer #(
   parameter int depth  = 24,
   parameter int data_w = 256,
   parameter int addr_w = 5
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [addr_w-1:0] waddr_i,
   input  logic [data_w-1:0] wdata_i,
   input  logic [addr_w-1:0] raddr_a_i,
   output logic [data_w-1:0] rdata_a_o,
   input  logic [addr_w-1:0] raddr_b_i,
   output logic [data_w-1:0] rdata_b_o
);

   // Contents are don't-care after reset, so no reset keeps this mappable to distributed RAM
   logic [data_w-1:0] mem_q [depth];

   // Store the even-row pixel at its column
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/layer1_pool_window_buffer.sv
// rtl/layer1_pool_window_buffer.sv - raster pixel stream to packed 2x2 pool windows
module layer1_pool_window_buffer
   import layer1_pool_window_buffer_pkg::*;
#(
   parameter int bits        = pool_bits,
   parameter int bits_shift  = pool_bits_shift,
   parameter int channel_num = pool_channel_num,
   parameter int img_width   = pool_img_width,
   parameter int img_height  = pool_img_height,
   parameter int cnt_bits    = pool_cnt_bits
) (
   input  logic                                    clk_in,
   input  logic                                    rst_n,
   input  logic [(channel_num<<bits_shift)-1:0]     pix_in,
   input  logic                                    pix_valid,
   input  logic                                    sof,
   output logic [(channel_num<<(bits_shift+2))-1:0] win_out,
   output logic                                    win_start,
   output logic                                    frame_done
);

   localparam int pix_w = channel_num << bits_shift;
   localparam int win_w = channel_num << (bits_shift + 2);
   localparam int lb_aw = (img_width > 1) ? $clog2(img_width) : 1;

   localparam logic [cnt_bits-1:0] col_max  = cnt_bits'(img_width - 1);
   localparam logic [cnt_bits-1:0] row_max  = cnt_bits'(img_height - 1);
   // An odd trailing column/row is never paired, so the last window sits one short of it
   localparam logic [cnt_bits-1:0] last_col = cnt_bits'(2 * (img_width / 2) - 1);
   localparam logic [cnt_bits-1:0] last_row = cnt_bits'(2 * (img_height / 2) - 1);

   logic [cnt_bits-1:0] col_q, col_d, row_q, row_d;
   logic [cnt_bits-1:0] cur_col, cur_row;
   logic [pix_w-1:0]    left_q, left_d;
   logic [win_w-1:0]    win_q, win_d;
   logic                start_q, start_d, done_q, done_d;
   logic                lb_we, fire;
   logic [lb_aw-1:0]    lb_waddr, lb_raddr_tl, lb_raddr_tr;
   logic [pix_w-1:0]    lb_rd_tl, lb_rd_tr;

   // Position of the incoming pixel: sof with a valid pixel forces (0,0)
   always_comb begin
      cur_col = col_q;
      cur_row = row_q;
      if (pix_valid && sof) begin
         cur_col = '0;
         cur_row = '0;
      end
   end

   // Raster counters advance only on accepted pixels
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (pix_valid) begin
         if (cur_col == col_max) begin
            col_d = '0;
            row_d = (cur_row == row_max) ? '0 : cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
         end
      end
   end

   assign lb_we       = pix_valid & ~cur_row[0];
   assign fire        = pix_valid & cur_row[0] & cur_col[0];
   assign lb_waddr    = cur_col[lb_aw-1:0];
   assign lb_raddr_tr = cur_col[lb_aw-1:0];
   // On an odd column the even neighbour is the same address with bit 0 cleared
   assign lb_raddr_tl = cur_col[lb_aw-1:0] & ~lb_aw'(1);

   layer1_pool_window_buffer_pool_line_buffer #(
      .depth  (img_width),
      .data_w (pix_w),
      .addr_w (lb_aw)
   ) u_line_buf (
      .clk_i     (clk_in),
      .we_i      (lb_we),
      .waddr_i   (lb_waddr),
      .wdata_i   (pix_in),
      .raddr_a_i (lb_raddr_tl),
      .rdata_a_o (lb_rd_tl),
      .raddr_b_i (lb_raddr_tr),
      .rdata_b_o (lb_rd_tr)
   );

   // Hold the bottom-left pixel of the window being assembled
   always_comb begin
      left_d = left_q;
      if (pix_valid && cur_row[0] && !cur_col[0]) begin
         left_d = pix_in;
      end
   end

   // Pack the completed 2x2 block per channel and raise the pulses
   always_comb begin
      win_d   = win_q;
      start_d = 1'b0;
      done_d  = 1'b0;
      if (fire) begin
         for (int i = 0; i < channel_num; i++) begin
            win_d[(i << (bits_shift + 2)) + win_off_tl +: bits] = lb_rd_tl[(i << bits_shift) +: bits];
            win_d[(i << (bits_shift + 2)) + win_off_tr +: bits] = lb_rd_tr[(i << bits_shift) +: bits];
            win_d[(i << (bits_shift + 2)) + win_off_bl +: bits] = left_q[(i << bits_shift) +: bits];
            win_d[(i << (bits_shift + 2)) + win_off_br +: bits] = pix_in[(i << bits_shift) +: bits];
         end
         start_d = 1'b1;
         done_d  = (cur_row == last_row) && (cur_col == last_col);
      end
   end

   // State and output registers
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         col_q   <= '0;
         row_q   <= '0;
         left_q  <= '0;
         win_q   <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         left_q  <= left_d;
         win_q   <= win_d;
         start_q <= start_d;
         done_q  <= done_d;
      end
   end

   assign win_out    = win_q;
   assign win_start  = start_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_layer1_pool_window_buffer.sv
// tb/tb_layer1_pool_window_buffer.sv - self-checking bench for layer1_pool_window_buffer
module tb_layer1_pool_window_buffer;

   typedef struct {
      int          r;
      int          c;
      logic [63:0] ch0;
      logic [63:0] ch1;
   } vec_t;

   typedef struct {
      int           step;
      logic [127:0] win;
   } cap_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  pix = '0;
   logic         pv = 1'b0;
   logic         sof = 1'b0;
   logic [127:0] win4, win5;
   logic         st4, st5, fd4, fd5;

   int checks = 0;
   int errors = 0;
   int g_step = 0;
   int base = 0;

   vec_t tbl[4];
   cap_t cap4[$], cap5[$];
   int   fd4q[$], fd5q[$];

   // Reference model: whole-frame image store per DUT, indexed by (row, col)
   logic [31:0]  img [2][8][8];
   int           m_r[2], m_c[2];
   int           mw[2] = '{4, 5};
   int           mh[2] = '{4, 5};
   logic [127:0] e_win[2];
   logic         e_st[2], e_fd[2];

   always #5 clk = ~clk;

   layer1_pool_window_buffer #(
      .bits(16), .bits_shift(4), .channel_num(2), .img_width(4), .img_height(4), .cnt_bits(5)
   ) dut4 (
      .clk_in(clk), .rst_n(rst_n), .pix_in(pix), .pix_valid(pv), .sof(sof),
      .win_out(win4), .win_start(st4), .frame_done(fd4)
   );

   layer1_pool_window_buffer #(
      .bits(16), .bits_shift(4), .channel_num(2), .img_width(5), .img_height(5), .cnt_bits(5)
   ) dut5 (
      .clk_in(clk), .rst_n(rst_n), .pix_in(pix), .pix_valid(pv), .sof(sof),
      .win_out(win5), .win_start(st5), .frame_done(fd5)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] pixval(input int r, input int c);
      logic [15:0] v0;
      v0 = 16'(r * 16 + c);
      return {16'h0100 + v0, v0};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_r[d] = 0; m_c[d] = 0;
         e_win[d] = '0; e_st[d] = 1'b0; e_fd[d] = 1'b0;
      end
   endtask

   task automatic model_step(input int d, input logic v, input logic s, input logic [31:0] p);
      int r, c;
      e_st[d] = 1'b0;
      e_fd[d] = 1'b0;
      if (!v) return;
      if (s) begin
         m_r[d] = 0; m_c[d] = 0;
      end
      r = m_r[d];
      c = m_c[d];
      img[d][r][c] = p;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
         for (int ch = 0; ch < 2; ch++) begin
            e_win[d][ch*64 +: 64] = {p[ch*16 +: 16], img[d][r][c-1][ch*16 +: 16],
                                     img[d][r-1][c][ch*16 +: 16], img[d][r-1][c-1][ch*16 +: 16]};
         end
         e_st[d] = 1'b1;
         e_fd[d] = (r == 2 * (mh[d] / 2) - 1) && (c == 2 * (mw[d] / 2) - 1);
      end
      c++;
      if (c == mw[d]) begin
         c = 0;
         r++;
         if (r == mh[d]) r = 0;
      end
      m_r[d] = r;
      m_c[d] = c;
   endtask

   task automatic compare_all();
      chk("win_start4", 128'(st4), 128'(e_st[0]));
      chk("frame_done4", 128'(fd4), 128'(e_fd[0]));
      chk("win_out4", win4, e_win[0]);
      chk("win_start5", 128'(st5), 128'(e_st[1]));
      chk("frame_done5", 128'(fd5), 128'(e_fd[1]));
      chk("win_out5", win5, e_win[1]);
      if (st4 === 1'b1) cap4.push_back('{g_step - base, win4});
      if (st5 === 1'b1) cap5.push_back('{g_step - base, win5});
      if (fd4 === 1'b1) fd4q.push_back(g_step - base);
      if (fd5 === 1'b1) fd5q.push_back(g_step - base);
   endtask

   task automatic step(input logic v, input logic s, input logic [31:0] p);
      pv = v; sof = s; pix = p;
      @(posedge clk);
      #1;
      model_step(0, v, s, p);
      model_step(1, v, s, p);
      compare_all();
      g_step++;
   endtask

   task automatic clear_caps();
      cap4.delete(); cap5.delete(); fd4q.delete(); fd5q.delete();
      base = g_step;
   endtask

   // Raster pixels of a w-wide frame, first one with sof; stride>1 inserts idle cycles
   task automatic send_pixels(input int w, input int n, input int stride);
      for (int k = 0; k < n; k++) begin
         step(1'b1, k == 0, pixval(k / w, k % w));
         for (int g = 1; g < stride; g++) step(1'b0, 1'b0, $urandom);
      end
   endtask

   task automatic check_windows(input string nm, input int d, input int w, input int stride);
      cap_t q[$];
      if (d == 0) q = cap4; else q = cap5;
      chk({nm, "_count"}, 128'(q.size()), 128'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < q.size()) begin
            chk($sformatf("%s_w%0d_ch0", nm, i), 128'(q[i].win[63:0]), 128'(tbl[i].ch0));
            chk($sformatf("%s_w%0d_ch1", nm, i), 128'(q[i].win[127:64]), 128'(tbl[i].ch1));
            chk($sformatf("%s_w%0d_cycle", nm, i), 128'(q[i].step),
                128'((tbl[i].r * w + tbl[i].c) * stride));
         end
      end
   endtask

   initial begin
      tbl[0] = '{1, 1, 64'h0011_0010_0001_0000, 64'h0111_0110_0101_0100};
      tbl[1] = '{1, 3, 64'h0013_0012_0003_0002, 64'h0113_0112_0103_0102};
      tbl[2] = '{3, 1, 64'h0031_0030_0021_0020, 64'h0131_0130_0121_0120};
      tbl[3] = '{3, 3, 64'h0033_0032_0023_0022, 64'h0133_0132_0123_0122};
      model_reset();

      // Reset state
      step(1'b0, 1'b0, '0);
      chk("reset_win_out", win4, '0);
      chk("reset_win_start", 128'(st4), '0);
      chk("reset_frame_done", 128'(fd4), '0);
      rst_n = 1'b1;
      step(1'b0, 1'b0, '0);

      // 1: one frame, continuous valid
      clear_caps();
      send_pixels(4, 16, 1);
      step(1'b0, 1'b0, '0);
      check_windows("t1", 0, 4, 1);
      chk("t1_frame_done_count", 128'(fd4q.size()), 128'(1));

      // 2: valid toggling
      clear_caps();
      send_pixels(4, 16, 2);
      check_windows("t2", 0, 4, 2);

      // 3: 5x5 frame, odd column/row discarded
      clear_caps();
      send_pixels(5, 25, 1);
      step(1'b0, 1'b0, '0);
      check_windows("t3", 1, 5, 1);
      chk("t3_frame_done_count", 128'(fd5q.size()), 128'(1));
      if (fd5q.size() > 0) chk("t3_frame_done_cycle", 128'(fd5q[0]), 128'(18));

      // 4: sof at pixel (3,2) aborts the frame
      clear_caps();
      send_pixels(4, 14, 1);
      chk("t4_aborted_windows", 128'(cap4.size()), 128'(3));
      clear_caps();
      send_pixels(4, 16, 1);
      step(1'b0, 1'b0, '0);
      check_windows("t4", 0, 4, 1);
      chk("t4_frame_done_count", 128'(fd4q.size()), 128'(1));

      // 5: asynchronous reset at pixel (1,0)
      send_pixels(4, 5, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5_async_win_out4", win4, '0);
      chk("t5_async_win_out5", win5, '0);
      chk("t5_async_win_start", 128'(st4), '0);
      chk("t5_async_frame_done", 128'(fd4), '0);
      model_reset();
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      rst_n = 1'b1;
      clear_caps();
      send_pixels(4, 16, 1);
      check_windows("t5", 0, 4, 1);

      // 6: two frames back-to-back
      clear_caps();
      send_pixels(4, 16, 1);
      send_pixels(4, 16, 1);
      step(1'b0, 1'b0, '0);
      chk("t6_win_count", 128'(cap4.size()), 128'(8));
      chk("t6_frame_done_count", 128'(fd4q.size()), 128'(2));
      if (fd4q.size() == 2) chk("t6_frame_done_spacing", 128'(fd4q[1] - fd4q[0]), 128'(16));

      // Random valid gaps, pixel values and occasional sof, checked every cycle by the model
      for (int k = 0; k < 800; k++) begin
         step(($urandom % 4) != 0, ($urandom % 40) == 0, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
